// File: rtl/bp_be_pkg.sv
// Shared Sv39 types and constants for the backend page-table walker.
package bp_be_pkg;

  localparam int sv39_levels_gp        = 3;
  localparam int sv39_vpn_seg_width_gp = 9;
  localparam int sv39_pte_bytes_gp     = 8;

  typedef enum logic [2:0] {
    e_ptw_idle,
    e_ptw_send,
    e_ptw_wait,
    e_ptw_fill,
    e_ptw_fault
  } bp_be_ptw_state_e;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } bp_be_sv39_pte_s;

endpackage

// File: rtl/bp_be_ptw_pte_decode.sv
// Combinational Sv39 PTE decode: validity, leaf/superpage alignment, next-level PPN
// and the fill PPN with the untranslated low VPN segments merged in.
module bp_be_ptw_pte_decode
  import bp_be_pkg::*;
#(
  parameter int vtag_width_p = 27,
  parameter int ptag_width_p = 28,
  parameter int pte_width_p  = 64
) (
  input  logic [pte_width_p-1:0]  i_pte,
  input  logic [1:0]              i_level,
  input  logic [vtag_width_p-1:0] i_vtag,
  output logic                    o_invalid,
  output logic                    o_leaf,
  output logic                    o_misaligned,
  output logic                    o_accessed,
  output logic [ptag_width_p-1:0] o_next_ppn,
  output logic [ptag_width_p-1:0] o_leaf_ptag
);

  localparam int seg_lp = sv39_vpn_seg_width_gp;

  bp_be_sv39_pte_s         w_pte;
  logic [ptag_width_p-1:0] w_ppn;
  logic                    w_unused;

  assign w_pte = i_pte;
  assign w_ppn = w_pte.ppn[ptag_width_p-1:0];

  // Reserved/RSW/D/G/U and PPN bits above the physical tag play no part in translation
  assign w_unused = ^{w_pte.reserved, w_pte.ppn[43:ptag_width_p], w_pte.rsw,
                      w_pte.d, w_pte.g, w_pte.u, i_vtag[vtag_width_p-1:2*seg_lp]};

  assign o_invalid  = ~w_pte.v | (w_pte.w & ~w_pte.r);
  assign o_leaf     = w_pte.r | w_pte.x;
  assign o_accessed = w_pte.a;
  assign o_next_ppn = w_ppn;

  // A superpage leaf must have zero PPN bits below its level; those come from the VPN
  always_comb begin
    o_misaligned = 1'b0;
    o_leaf_ptag  = w_ppn;
    case (i_level)
      2'd2: begin
        o_misaligned = |w_ppn[2*seg_lp-1:0];
        o_leaf_ptag  = {w_ppn[ptag_width_p-1:2*seg_lp], i_vtag[2*seg_lp-1:0]};
      end
      2'd1: begin
        o_misaligned = |w_ppn[seg_lp-1:0];
        o_leaf_ptag  = {w_ppn[ptag_width_p-1:seg_lp], i_vtag[seg_lp-1:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bp_be_ptw.sv
// Sv39 hardware page-table walker: turns TLB misses into 1-3 PTE reads and a fill or fault.
// Build option BP_BE_PTW_ACCESSED_CHECK_EN: leaves with A=0 fault instead of filling.
module bp_be_ptw
  import bp_be_pkg::*;
#(
  parameter int vtag_width_p = 27,
  parameter int ptag_width_p = 28,
  parameter int pte_width_p  = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [ptag_width_p-1:0]    satp_ppn_i,
  input  logic                       miss_v_i,
  input  logic [vtag_width_p-1:0]    miss_vtag_i,
  output logic                       busy_o,
  output logic                       mem_req_v_o,
  output logic [ptag_width_p+11:0]   mem_req_addr_o,
  input  logic                       mem_req_ready_i,
  input  logic                       mem_resp_v_i,
  input  logic [pte_width_p-1:0]     mem_resp_data_i,
  output logic                       w_v_o,
  output logic [vtag_width_p-1:0]    w_vtag_o,
  output logic [ptag_width_p-1:0]    w_ptag_o,
  output logic                       fault_v_o,
  output logic [vtag_width_p-1:0]    fault_vtag_o
);

  localparam int         seg_lp        = sv39_vpn_seg_width_gp;
  localparam int         off_lp        = $clog2(sv39_pte_bytes_gp);
  localparam logic [1:0] root_level_lp = 2'(sv39_levels_gp - 1);

  function automatic logic [seg_lp-1:0] vpn_seg(input logic [vtag_width_p-1:0] vtag,
                                                input logic [1:0]              level);
    case (level)
      2'd2:    return vtag[3*seg_lp-1:2*seg_lp];
      2'd1:    return vtag[2*seg_lp-1:seg_lp];
      default: return vtag[seg_lp-1:0];
    endcase
  endfunction

  bp_be_ptw_state_e        r_state;
  logic [vtag_width_p-1:0] r_vtag;
  logic [ptag_width_p-1:0] r_ppn;
  logic [1:0]              r_level;
  logic                    r_busy;
  logic                    r_req_v;
  logic                    r_w_v;
  logic [vtag_width_p-1:0] r_w_vtag;
  logic [ptag_width_p-1:0] r_w_ptag;
  logic                    r_fault_v;
  logic [vtag_width_p-1:0] r_fault_vtag;

  logic                    w_invalid;
  logic                    w_leaf;
  logic                    w_misaligned;
  logic                    w_accessed;
  logic                    w_acc_fault;
  logic                    w_fault;
  logic [ptag_width_p-1:0] w_next_ppn;
  logic [ptag_width_p-1:0] w_leaf_ptag;

  bp_be_ptw_pte_decode #(
    .vtag_width_p (vtag_width_p),
    .ptag_width_p (ptag_width_p),
    .pte_width_p  (pte_width_p)
  ) u_decode (
    .i_pte        (mem_resp_data_i),
    .i_level      (r_level),
    .i_vtag       (r_vtag),
    .o_invalid    (w_invalid),
    .o_leaf       (w_leaf),
    .o_misaligned (w_misaligned),
    .o_accessed   (w_accessed),
    .o_next_ppn   (w_next_ppn),
    .o_leaf_ptag  (w_leaf_ptag)
  );

`ifdef BP_BE_PTW_ACCESSED_CHECK_EN
  assign w_acc_fault = ~w_accessed;
`else
  logic w_unused_acc;
  assign w_unused_acc = w_accessed;
  assign w_acc_fault  = 1'b0;
`endif

  // A non-leaf at the last level has nowhere left to point
  assign w_fault = w_invalid
                 | (w_leaf & (w_misaligned | w_acc_fault))
                 | (~w_leaf & (r_level == 2'd0));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= e_ptw_idle;
      r_vtag       <= '0;
      r_ppn        <= '0;
      r_level      <= '0;
      r_busy       <= 1'b0;
      r_req_v      <= 1'b0;
      r_w_v        <= 1'b0;
      r_w_vtag     <= '0;
      r_w_ptag     <= '0;
      r_fault_v    <= 1'b0;
      r_fault_vtag <= '0;
    end else begin
      r_w_v     <= 1'b0;
      r_fault_v <= 1'b0;
      case (r_state)
        e_ptw_idle: begin
          if (miss_v_i) begin
            r_vtag  <= miss_vtag_i;
            r_ppn   <= satp_ppn_i;
            r_level <= root_level_lp;
            r_busy  <= 1'b1;
            r_req_v <= 1'b1;
            r_state <= e_ptw_send;
          end
        end
        e_ptw_send: begin
          if (mem_req_ready_i) begin
            r_req_v <= 1'b0;
            r_state <= e_ptw_wait;
          end
        end
        e_ptw_wait: begin
          if (mem_resp_v_i) begin
            if (w_fault) begin
              r_fault_v    <= 1'b1;
              r_fault_vtag <= r_vtag;
              r_state      <= e_ptw_fault;
            end else if (w_leaf) begin
              r_w_v    <= 1'b1;
              r_w_vtag <= r_vtag;
              r_w_ptag <= w_leaf_ptag;
              r_state  <= e_ptw_fill;
            end else begin
              r_ppn   <= w_next_ppn;
              r_level <= r_level - 2'd1;
              r_req_v <= 1'b1;
              r_state <= e_ptw_send;
            end
          end
        end
        e_ptw_fill, e_ptw_fault: begin
          r_busy  <= 1'b0;
          r_state <= e_ptw_idle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_req_v <= 1'b0;
          r_state <= e_ptw_idle;
        end
      endcase
    end
  end

  // Address is a pure function of walk registers, so it holds while the request stalls
  assign mem_req_addr_o = {r_ppn, vpn_seg(r_vtag, r_level), {off_lp{1'b0}}};
  assign mem_req_v_o    = r_req_v;
  assign busy_o         = r_busy;
  assign w_v_o          = r_w_v;
  assign w_vtag_o       = r_w_vtag;
  assign w_ptag_o       = r_w_ptag;
  assign fault_v_o      = r_fault_v;
  assign fault_vtag_o   = r_fault_vtag;

endmodule

// File: tb/tb_bp_be_ptw.sv
// Testbench for bp_be_ptw: page-table memory model plus a walk-level reference model.
module tb_bp_be_ptw;

  localparam int VT = 27;
  localparam int PT = 28;
  localparam int AW = PT + 12;
`ifdef BP_BE_PTW_ACCESSED_CHECK_EN
  localparam bit ACC_CHECK = 1'b1;
`else
  localparam bit ACC_CHECK = 1'b0;
`endif
  localparam logic [7:0] F_NL   = 8'h01;
  localparam logic [7:0] F_LEAF = 8'h43;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [PT-1:0] satp_ppn_i = '0;
  logic          miss_v_i = 1'b0;
  logic [VT-1:0] miss_vtag_i = '0;
  logic          busy_o, mem_req_v_o, w_v_o, fault_v_o;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_req_ready_i;
  logic          mem_resp_v_i;
  logic [63:0]   mem_resp_data_i;
  logic [VT-1:0] w_vtag_o, fault_vtag_o;
  logic [PT-1:0] w_ptag_o;

  logic          auto_resp = 1'b1;
  logic          auto_v, man_v = 1'b0;
  logic [63:0]   auto_data, man_data = '0;
  int            ready_mode = 0;

  logic [63:0]   mem [logic [AW-1:0]];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [56:0]   exp_res;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  assign mem_resp_v_i    = auto_v | man_v;
  assign mem_resp_data_i = man_v ? man_data : auto_data;

  bp_be_ptw dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .satp_ppn_i      (satp_ppn_i),
    .miss_v_i        (miss_v_i),
    .miss_vtag_i     (miss_vtag_i),
    .busy_o          (busy_o),
    .mem_req_v_o     (mem_req_v_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_data_i (mem_resp_data_i),
    .w_v_o           (w_v_o),
    .w_vtag_o        (w_vtag_o),
    .w_ptag_o        (w_ptag_o),
    .fault_v_o       (fault_v_o),
    .fault_vtag_o    (fault_vtag_o)
  );

  // Ready driver: 0 = always ready, 1 = random, 2 = held low
  initial begin
    mem_req_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       mem_req_ready_i = 1'b1;
        1:       mem_req_ready_i = 1'($urandom_range(0, 1));
        default: mem_req_ready_i = 1'b0;
      endcase
    end
  end

  // Memory: one response the cycle after each accepted request
  initial begin
    logic        pend;
    logic [63:0] d;
    auto_v = 1'b0;
    auto_data = '0;
    d = '0;
    forever begin
      @(negedge clk);
      pend = auto_resp && reset_n_i && mem_req_v_o && mem_req_ready_i;
      if (pend) begin
        addr_q.push_back(mem_req_addr_o);
        d = mem.exists(mem_req_addr_o) ? mem[mem_req_addr_o] : 64'd0;
      end
      @(posedge clk);
      #1;
      if (pend) begin
        auto_v = 1'b1;
        auto_data = d;
        @(posedge clk);
        #1;
        auto_v = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] pa(input logic [PT-1:0] ppn, input logic [VT-1:0] vtag,
                                       input int lvl);
    logic [63:0] x;
    x = 64'(ppn) * 4096 + ((64'(vtag) >> (9 * lvl)) & 64'h1FF) * 8;
    return x[AW-1:0];
  endfunction

  function automatic logic [63:0] mk_pte(input logic [PT-1:0] ppn, input logic [7:0] flags);
    return {10'd0, 16'd0, ppn, 2'd0, flags};
  endfunction

  function automatic logic [127:0] pack_q(input logic [AW-1:0] q[$]);
    logic [127:0] p;
    p = {8'(q.size()), 120'd0};
    for (int i = 0; i < 3 && i < q.size(); i++) p[120 - AW*(i+1) +: AW] = q[i];
    return p;
  endfunction

  // Reference walk: Sv39 rules applied directly to the memory image
  task automatic model_walk(input logic [PT-1:0] satp, input logic [VT-1:0] vtag);
    logic [63:0]   ppn, pte, p, mask;
    logic [AW-1:0] a;
    exp_addr_q.delete();
    ppn = 64'(satp);
    for (int lvl = 2; lvl >= 0; lvl--) begin
      a = pa(ppn[PT-1:0], vtag, lvl);
      exp_addr_q.push_back(a);
      pte = mem.exists(a) ? mem[a] : 64'd0;
      p = (pte >> 10) & ((64'd1 << PT) - 1);
      if (!pte[0] || (pte[2] && !pte[1])) begin
        exp_res = {2'b01, 28'd0, vtag};
        return;
      end
      if (pte[1] || pte[3]) begin
        mask = (64'd1 << (9 * lvl)) - 1;
        if ((p & mask) != 0 || (ACC_CHECK && !pte[6])) exp_res = {2'b01, 28'd0, vtag};
        else exp_res = {2'b10, 28'((p & ~mask) | (64'(vtag) & mask)), vtag};
        return;
      end
      if (lvl == 0) begin
        exp_res = {2'b01, 28'd0, vtag};
        return;
      end
      ppn = p;
    end
  endtask

  task automatic build_random(input logic [PT-1:0] satp, input logic [VT-1:0] vtag);
    logic [PT-1:0] ppn, np;
    logic [7:0]    f;
    int            k, rx;
    mem.delete();
    ppn = satp;
    for (int lvl = 2; lvl >= 0; lvl--) begin
      k  = $urandom_range(0, 9);
      np = PT'($urandom);
      if (k == 0)      f = 8'($urandom) & 8'hFE;
      else if (k == 1) f = 8'h05 | (8'($urandom) & 8'hC8);
      else if (k <= 4) begin
        rx = $urandom_range(1, 3);
        f = 8'h01 | (rx[0] ? 8'h02 : 8'h00) | (rx[1] ? 8'h08 : 8'h00) | (8'($urandom) & 8'hB4);
        if ($urandom_range(0, 4) != 0) f = f | 8'h40;
        if (lvl > 0 && $urandom_range(0, 1) == 1) np = np & ~PT'((1 << (9 * lvl)) - 1);
      end else f = 8'h01 | (8'($urandom) & 8'hF0);
      mem[pa(ppn, vtag, lvl)] = {10'($urandom), 16'($urandom), np, 2'($urandom), f};
      if (k <= 4) break;
      ppn = np;
    end
  endtask

  // One walk; observed result packs {fill, fault, ptag, vtag} like the model
  task automatic run_walk(input logic [PT-1:0] satp, input logic [VT-1:0] vtag,
                          input int stall, input int pulse_at,
                          output logic [56:0] res, output int lat,
                          output bit busy_ok, output bit tail_ok, output bit stall_ok);
    logic [AW-1:0] first_addr;
    addr_q.delete();
    res = '0; lat = 0; busy_ok = 1'b1; tail_ok = 1'b1; stall_ok = 1'b1; first_addr = '0;
    if (stall > 0) ready_mode = 2;
    satp_ppn_i = satp; miss_vtag_i = vtag; miss_v_i = 1'b1;
    @(posedge clk); #1;
    miss_v_i = 1'b0; satp_ppn_i = PT'($urandom); miss_vtag_i = VT'($urandom);
    for (int c = 1; c < 400; c++) begin
      if (c == 1) first_addr = mem_req_addr_o;
      if (c <= stall + 1 && stall > 0) begin
        if (!(mem_req_v_o && mem_req_addr_o == first_addr)) stall_ok = 1'b0;
        if (c == stall + 1) ready_mode = 0;
      end
      if (c == pulse_at) begin
        miss_v_i = 1'b1; miss_vtag_i = VT'($urandom);
      end else miss_v_i = 1'b0;
      if (!busy_o) busy_ok = 1'b0;
      if (w_v_o || fault_v_o) begin
        lat = c;
        res = {w_v_o, fault_v_o, w_v_o ? w_ptag_o : 28'd0, w_v_o ? w_vtag_o : fault_vtag_o};
        break;
      end
      @(posedge clk); #1;
    end
    miss_v_i = 1'b0;
    @(posedge clk); #1;
    if (w_v_o || fault_v_o || busy_o) tail_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [125:0] obs;
    satp_ppn_i = PT'($urandom); miss_vtag_i = VT'($urandom); miss_v_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {busy_o, mem_req_v_o, w_v_o, fault_v_o, mem_req_addr_o, w_vtag_o, w_ptag_o, fault_vtag_o};
    n_cmp++;
    if (obs !== 126'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", obs);
    end
    miss_v_i = 1'b0;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy_o, mem_req_v_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release_idle: got %b want 00", {busy_o, mem_req_v_o});
    end
  endtask

  task automatic setup_4k();
    mem.delete();
    mem[pa(28'h100, 27'h0040201, 2)] = mk_pte(28'h200, F_NL);
    mem[pa(28'h200, 27'h0040201, 1)] = mk_pte(28'h300, F_NL);
    mem[pa(28'h300, 27'h0040201, 0)] = mk_pte(28'hABCDE, F_LEAF);
  endtask

  task automatic test_walk_4k();
    logic [56:0] res; int lat; bit bok, tok, sok;
    setup_4k();
    model_walk(28'h100, 27'h0040201);
    run_walk(28'h100, 27'h0040201, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== exp_res) begin n_fail++; $display("FAIL walk4k_result: got %h want %h", res, exp_res); end
    n_cmp++;
    if (res !== {2'b10, 28'hABCDE, 27'h0040201}) begin
      n_fail++; $display("FAIL walk4k_ptag: got %h want fill ABCDE", res);
    end
    n_cmp++;
    if (pack_q(addr_q) !== pack_q(exp_addr_q)) begin
      n_fail++; $display("FAIL walk4k_addrs: got %h want %h", pack_q(addr_q), pack_q(exp_addr_q));
    end
    // Fill appears in the 8th cycle counting the miss cycle
    n_cmp++;
    if (lat !== 7) begin n_fail++; $display("FAIL walk4k_latency: got %0d want 7", lat); end
    n_cmp++;
    if ({bok, tok} !== 2'b11) begin n_fail++; $display("FAIL walk4k_busy_pulse: got %b want 11", {bok, tok}); end
  endtask

  task automatic test_superpage();
    logic [56:0] res; int lat; bit bok, tok, sok;
    mem.delete();
    mem[pa(28'h1234, 27'h0000123, 2)] = mk_pte(28'h555, F_NL);
    mem[pa(28'h555, 27'h0000123, 1)]  = mk_pte(28'h40000, F_LEAF);
    model_walk(28'h1234, 27'h0000123);
    run_walk(28'h1234, 27'h0000123, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== {2'b10, 28'h40123, 27'h0000123}) begin
      n_fail++; $display("FAIL super_aligned: got %h want fill 40123", res);
    end
    n_cmp++;
    if (pack_q(addr_q) !== pack_q(exp_addr_q) || addr_q.size() != 2) begin
      n_fail++; $display("FAIL super_addrs: got %h want %h", pack_q(addr_q), pack_q(exp_addr_q));
    end
    n_cmp++;
    if (lat !== 5) begin n_fail++; $display("FAIL super_latency: got %0d want 5", lat); end
    mem[pa(28'h555, 27'h0000123, 1)] = mk_pte(28'h40001, F_LEAF);
    run_walk(28'h1234, 27'h0000123, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== {2'b01, 28'd0, 27'h0000123}) begin
      n_fail++; $display("FAIL super_misaligned: got %h want fault 0000123", res);
    end
  endtask

  task automatic test_faults();
    logic [56:0] res; int lat; bit bok, tok, sok;
    logic [VT-1:0] vt;
    vt = VT'($urandom);
    mem.delete();
    model_walk(28'h777, vt);
    run_walk(28'h777, vt, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== {2'b01, 28'd0, vt} || addr_q.size() != 1) begin
      n_fail++; $display("FAIL fault_root_invalid: got %h n=%0d want fault n=1", res, addr_q.size());
    end
    mem[pa(28'h777, vt, 2)] = mk_pte(28'h888, F_NL);
    mem[pa(28'h888, vt, 1)] = mk_pte(28'h999, F_NL);
    mem[pa(28'h999, vt, 0)] = mk_pte(28'hAAA, F_NL);
    model_walk(28'h777, vt);
    run_walk(28'h777, vt, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== exp_res || addr_q.size() != 3) begin
      n_fail++; $display("FAIL fault_l0_nonleaf: got %h n=%0d want %h n=3", res, addr_q.size(), exp_res);
    end
    mem[pa(28'h888, vt, 1)] = mk_pte(28'h999, 8'h45);
    run_walk(28'h777, vt, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== {2'b01, 28'd0, vt}) begin
      n_fail++; $display("FAIL fault_w_without_r: got %h want fault", res);
    end
  endtask

  task automatic test_stall_ignore();
    logic [56:0] res; int lat; bit bok, tok, sok;
    setup_4k();
    model_walk(28'h100, 27'h0040201);
    run_walk(28'h100, 27'h0040201, 5, 3, res, lat, bok, tok, sok);
    n_cmp++;
    if (sok !== 1'b1) begin n_fail++; $display("FAIL stall_addr_stable: got %b want 1", sok); end
    n_cmp++;
    if (res !== exp_res || pack_q(addr_q) !== pack_q(exp_addr_q)) begin
      n_fail++; $display("FAIL stall_walk: got %h want %h", res, exp_res);
    end
    n_cmp++;
    if ({bok, tok} !== 2'b11) begin n_fail++; $display("FAIL stall_busy: got %b want 11", {bok, tok}); end
  endtask

  task automatic test_reset_midwalk();
    logic [56:0] res; int lat; bit bok, tok, sok, quiet;
    setup_4k();
    auto_resp = 1'b0;
    satp_ppn_i = 28'h100; miss_vtag_i = 27'h0040201; miss_v_i = 1'b1;
    @(posedge clk); #1;
    miss_v_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, mem_req_v_o, w_v_o, fault_v_o} !== 4'b0000) begin
      n_fail++; $display("FAIL midwalk_reset_async: got %b want 0000", {busy_o, mem_req_v_o, w_v_o, fault_v_o});
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    man_data = mk_pte(28'hABCDE, F_LEAF);
    man_v = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      man_v = 1'b0;
      if (w_v_o || fault_v_o || busy_o) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin n_fail++; $display("FAIL midwalk_stale_resp: got %b want 1", quiet); end
    auto_resp = 1'b1;
    model_walk(28'h100, 27'h0040201);
    run_walk(28'h100, 27'h0040201, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== exp_res || pack_q(addr_q) !== pack_q(exp_addr_q)) begin
      n_fail++; $display("FAIL midwalk_next_walk: got %h want %h", res, exp_res);
    end
  endtask

  task automatic test_accessed();
    logic [56:0] res; int lat; bit bok, tok, sok;
    setup_4k();
    mem[pa(28'h300, 27'h0040201, 0)] = mk_pte(28'hABCDE, 8'h03);
    model_walk(28'h100, 27'h0040201);
    run_walk(28'h100, 27'h0040201, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res[56:55] !== (ACC_CHECK ? 2'b01 : 2'b10) || res !== exp_res) begin
      n_fail++; $display("FAIL accessed_bit: got %h want %h", res, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    logic [56:0] res; int lat; bit bok, tok, sok;
    setup_4k();
    model_walk(28'h100, 27'h0040201);
    run_walk(28'h100, 27'h0040201, 0, 0, res, lat, bok, tok, sok);
    run_walk(28'h100, 27'h0040201, 0, 0, res, lat, bok, tok, sok);
    n_cmp++;
    if (res !== exp_res || lat !== 7) begin
      n_fail++; $display("FAIL back_to_back: got %h lat %0d want %h lat 7", res, lat, exp_res);
    end
  endtask

  task automatic test_random();
    logic [56:0]   res; int lat; bit bok, tok, sok;
    logic [PT-1:0] satp;
    logic [VT-1:0] vt;
    for (int i = 0; i < 40; i++) begin
      ready_mode = i % 2;
      satp = PT'($urandom);
      vt = VT'($urandom);
      build_random(satp, vt);
      model_walk(satp, vt);
      run_walk(satp, vt, 0, 0, res, lat, bok, tok, sok);
      n_cmp++;
      if (res !== exp_res) begin
        n_fail++; $display("FAIL random_result[%0d]: got %h want %h", i, res, exp_res);
      end
      n_cmp++;
      if (pack_q(addr_q) !== pack_q(exp_addr_q) || {bok, tok} !== 2'b11) begin
        n_fail++; $display("FAIL random_addrs[%0d]: got %h/%b want %h/11", i, pack_q(addr_q), {bok, tok},
                            pack_q(exp_addr_q));
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_walk_4k();
    test_superpage();
    test_faults();
    test_stall_ignore();
    test_reset_midwalk();
    test_accessed();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
